rpn_sequencer: RTL and testbench

- Postfix (RPN) evaluation controller that sits directly upstream of the team's 8-deep x 4-bit Stack block.
- Also consumes the Stack's popped data.
- Accepts a token stream over a valid/ready handshake and translates it into single-cycle push/pop pulses.
- Operands are pushed; operators pop two values, compute a 4-bit result and push it back.
- Shadows the stack depth internally, so overflow and underflow are caught before the stack is ever driven.

---
 rtl/rpn_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_rpn_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_sequencer.sv
// rpn_sequencer: postfix (RPN) evaluation controller in front of an
// 8-deep x W-bit stack. Operand tokens become single-cycle pushes; operator
// tokens pop B then A, compute A op B (mod 2^W) and push the result back.
// Stack occupancy is shadowed locally so overflow/underflow are caught before
// the stack is ever driven. A rejected token still completes its handshake.
//
// Ports:
//   clk, rstN                  clock (rising edge), synchronous active-low reset
//   tok_valid/tok_ready        token handshake; tok_is_op selects operator
//   tok_data                   operand value, or opcode in [2:0]
//   clr_err                    clears the sticky error code
//   res_valid/res_data         one-cycle result pulse; res_data holds afterwards
//   err_code                   sticky first error: 01 ovf, 10 unf, 11 bad opcode
//   depth                      shadowed stack occupancy
//   stk_push/stk_pop/stk_data_in   stack controls
//   stk_data_out/stk_full/stk_empty_n  stack status (empty_n: 0 = empty)
//
// state  | meaning
// IDLE   | tok_ready=1, waiting for a token
// PUSH   | pushing an operand
// POP_B  | popping B (top of stack)
// POP_A  | popping A, B visible on stk_data_out
// CALC   | A visible on stk_data_out, result computed
// PUSH_R | pushing the result, res_valid pulse
module rpn_sequencer #(
    parameter int W     = 4,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         tok_valid,
    output logic         tok_ready,
    input  logic         tok_is_op,
    input  logic [W-1:0] tok_data,
    input  logic         clr_err,
    output logic         res_valid,
    output logic [W-1:0] res_data,
    output logic [1:0]   err_code,
    output logic [3:0]   depth,
    output logic         stk_push,
    output logic         stk_pop,
    output logic [W-1:0] stk_data_in,
    input  logic [W-1:0] stk_data_out,
    input  logic         stk_full,
    input  logic         stk_empty_n
);

    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNF  = 2'b10;
    localparam logic [1:0] ERR_OPC  = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PUSH   = 3'd1,
        POP_B  = 3'd2,
        POP_A  = 3'd3,
        CALC   = 3'd4,
        PUSH_R = 3'd5
    } state_t;

    state_t       state;
    logic [2:0]   op_q;
    logic [W-1:0] b_q;
    logic         accept;
    logic [1:0]   err_new;

    function automatic logic [W-1:0] alu(input logic [2:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign accept = tok_valid && tok_ready && (state == IDLE);

    // Error classification of the token being accepted this cycle.
    // An illegal opcode is reported ahead of an underflow.
    always_comb begin
        err_new = ERR_NONE;
        if (accept) begin
            if (!tok_is_op) begin
                if (depth == DEPTH_L || stk_full)
                    err_new = ERR_OVF;
            end else if (tok_data[2:0] > 3'd4) begin
                err_new = ERR_OPC;
            end else if (depth < 4'd2 || !stk_empty_n) begin
                err_new = ERR_UNF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state       <= IDLE;
            tok_ready   <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            err_code    <= ERR_NONE;
            depth       <= '0;
            stk_push    <= 1'b0;
            stk_pop     <= 1'b0;
            stk_data_in <= '0;
            op_q        <= '0;
            b_q         <= '0;
        end else begin
            stk_push  <= 1'b0;
            stk_pop   <= 1'b0;
            res_valid <= 1'b0;

            // A new error in the same cycle as clr_err replaces the cleared value.
            if (err_new != ERR_NONE && (err_code == ERR_NONE || clr_err))
                err_code <= err_new;
            else if (clr_err)
                err_code <= ERR_NONE;

            case (state)
                IDLE: begin
                    tok_ready <= 1'b1;
                    if (accept && err_new == ERR_NONE) begin
                        tok_ready <= 1'b0;
                        if (!tok_is_op) begin
                            stk_push    <= 1'b1;
                            stk_data_in <= tok_data;
                            state       <= PUSH;
                        end else begin
                            op_q    <= tok_data[2:0];
                            stk_pop <= 1'b1;
                            state   <= POP_B;
                        end
                    end
                end
                PUSH: begin
                    depth     <= depth + 4'd1;
                    tok_ready <= 1'b1;
                    state     <= IDLE;
                end
                POP_B: begin
                    depth   <= depth - 4'd1;
                    stk_pop <= 1'b1;
                    state   <= POP_A;
                end
                POP_A: begin
                    // stk_data_out now shows B from the POP_B pop.
                    depth <= depth - 4'd1;
                    b_q   <= stk_data_out;
                    state <= CALC;
                end
                CALC: begin
                    // stk_data_out now shows A; result goes straight to the push regs.
                    stk_data_in <= alu(op_q, stk_data_out, b_q);
                    res_data    <= alu(op_q, stk_data_out, b_q);
                    stk_push    <= 1'b1;
                    res_valid   <= 1'b1;
                    state       <= PUSH_R;
                end
                PUSH_R: begin
                    depth     <= depth + 4'd1;
                    tok_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    tok_ready <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Bench for rpn_sequencer with a behavioural 8 x 4 stack attached.
module tb_rpn_sequencer;

    logic       clk = 1'b0;
    logic       rstN;
    logic       tok_valid;
    logic       tok_ready;
    logic       tok_is_op;
    logic [3:0] tok_data;
    logic       clr_err;
    logic       res_valid;
    logic [3:0] res_data;
    logic [1:0] err_code;
    logic [3:0] depth;
    logic       stk_push;
    logic       stk_pop;
    logic [3:0] stk_data_in;
    logic [3:0] stk_data_out;
    logic       stk_full;
    logic       stk_empty_n;

    rpn_sequencer #(.W(4), .DEPTH(8)) dut (
        .clk(clk), .rstN(rstN),
        .tok_valid(tok_valid), .tok_ready(tok_ready),
        .tok_is_op(tok_is_op), .tok_data(tok_data),
        .clr_err(clr_err),
        .res_valid(res_valid), .res_data(res_data),
        .err_code(err_code), .depth(depth),
        .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_data_in(stk_data_in), .stk_data_out(stk_data_out),
        .stk_full(stk_full), .stk_empty_n(stk_empty_n)
    );

    always #5 clk = ~clk;

    // Stack model: registered data_out updated on the pop edge.
    logic [3:0] smem [8];
    logic [3:0] scnt;
    always @(posedge clk) begin
        if (!rstN) begin
            scnt         <= 4'd0;
            stk_data_out <= 4'd0;
        end else if (stk_push && scnt < 4'd8) begin
            smem[scnt[2:0]] <= stk_data_in;
            scnt            <= scnt + 4'd1;
        end else if (stk_pop && scnt > 4'd0) begin
            stk_data_out <= smem[3'(scnt - 4'd1)];
            scnt         <= scnt - 4'd1;
        end
    end
    assign stk_full    = (scnt == 4'd8);
    assign stk_empty_n = (scnt != 4'd0);

    int         push_cnt = 0, pop_cnt = 0, res_cnt = 0, both_cnt = 0;
    logic [3:0] last_res = 4'd0;
    always @(negedge clk) begin
        if (res_valid) begin res_cnt++; last_res = res_data; end
        if (stk_push) push_cnt++;
        if (stk_pop) pop_cnt++;
        if (stk_push && stk_pop) both_cnt++;
    end

    int tests = 0, fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!tok_ready && n < 20) begin tick(); n++; end
        if (!tok_ready) chk({name, " tok_ready timeout"}, 0, 1);
    endtask

    task automatic send(input logic is_op, input logic [3:0] data, input logic clr);
        wait_ready("send");
        tok_valid = 1'b1; tok_is_op = is_op; tok_data = data; clr_err = clr;
        tick();
        tok_valid = 1'b0; clr_err = 1'b0;
    endtask

    // kind: 0 operand, 1 operator, 2 clr_err only
    typedef struct {
        int         kind;
        logic       clr;
        logic [3:0] data;
        int         exp_res;
        logic [3:0] exp_val;
        logic [1:0] exp_err;
        logic [3:0] exp_depth;
        int         exp_push;
        int         exp_pop;
    } vec_t;

    function automatic vec_t mk(int kind, logic clr, logic [3:0] data, int er,
                                logic [3:0] ev, logic [1:0] ee, logic [3:0] ed,
                                int ep, int eo);
        vec_t v;
        v.kind = kind; v.clr = clr; v.data = data; v.exp_res = er; v.exp_val = ev;
        v.exp_err = ee; v.exp_depth = ed; v.exp_push = ep; v.exp_pop = eo;
        return v;
    endfunction

    vec_t vecs [20];

    initial begin
        int p0, q0, r0;

        // Stack before the table: [7], depth 1.
        vecs[0]  = mk(0, 0, 4'h3, 0, 4'h0, 2'b00, 4'd2, 1, 0);
        vecs[1]  = mk(0, 0, 4'h5, 0, 4'h0, 2'b00, 4'd3, 1, 0);
        vecs[2]  = mk(1, 0, 4'h1, 1, 4'hE, 2'b00, 4'd2, 1, 2); // 3-5 wraps
        vecs[3]  = mk(0, 0, 4'hF, 0, 4'h0, 2'b00, 4'd3, 1, 0);
        vecs[4]  = mk(1, 0, 4'h4, 1, 4'h1, 2'b00, 4'd2, 1, 2); // E^F
        vecs[5]  = mk(1, 0, 4'h3, 1, 4'h7, 2'b00, 4'd1, 1, 2); // 7|1
        vecs[6]  = mk(1, 0, 4'h0, 0, 4'h0, 2'b10, 4'd1, 0, 0); // underflow
        vecs[7]  = mk(1, 0, 4'h7, 0, 4'h0, 2'b10, 4'd1, 0, 0); // first error kept
        vecs[8]  = mk(1, 1, 4'h6, 0, 4'h0, 2'b11, 4'd1, 0, 0); // new error beats clr
        vecs[9]  = mk(2, 1, 4'h0, 0, 4'h0, 2'b00, 4'd1, 0, 0);
        vecs[10] = mk(0, 0, 4'h8, 0, 4'h0, 2'b00, 4'd2, 1, 0);
        vecs[11] = mk(1, 0, 4'h6, 0, 4'h0, 2'b11, 4'd2, 0, 0); // bad opcode at depth 2
        vecs[12] = mk(2, 1, 4'h0, 0, 4'h0, 2'b00, 4'd2, 0, 0);
        vecs[13] = mk(1, 0, 4'h2, 1, 4'h0, 2'b00, 4'd1, 1, 2); // 7&8
        vecs[14] = mk(0, 0, 4'h9, 0, 4'h0, 2'b00, 4'd2, 1, 0);
        vecs[15] = mk(1, 0, 4'h0, 1, 4'h9, 2'b00, 4'd1, 1, 2); // 0+9
        vecs[16] = mk(0, 0, 4'hF, 0, 4'h0, 2'b00, 4'd2, 1, 0);
        vecs[17] = mk(1, 0, 4'h0, 1, 4'h8, 2'b00, 4'd1, 1, 2); // 9+F wraps
        vecs[18] = mk(0, 0, 4'h2, 0, 4'h0, 2'b00, 4'd2, 1, 0);
        vecs[19] = mk(1, 0, 4'h1, 1, 4'h6, 2'b00, 4'd1, 1, 2); // 8-2

        rstN = 1'b0; tok_valid = 1'b0; tok_is_op = 1'b0; tok_data = 4'd0; clr_err = 1'b0;
        repeat (3) tick();
        chk("reset tok_ready", int'(tok_ready), 0);
        chk("reset depth", int'(depth), 0);
        chk("reset err", int'(err_code), 0);
        chk("reset res_valid", int'(res_valid), 0);
        chk("reset res_data", int'(res_data), 0);
        chk("reset push/pop", int'(stk_push) + int'(stk_pop), 0);
        rstN = 1'b1;
        tick();

        // push 3, push 4, ADD with cycle-level timing
        send(0, 4'h3, 0);
        chk("push3 stk_push", int'(stk_push), 1);
        chk("push3 data_in", int'(stk_data_in), 3);
        chk("push3 depth before edge", int'(depth), 0);
        tick();
        chk("push3 depth", int'(depth), 1);
        chk("push3 tok_ready back", int'(tok_ready), 1);
        send(0, 4'h4, 0);
        tick();
        chk("push4 depth", int'(depth), 2);
        send(1, 4'h0, 0);
        chk("add N tok_ready", int'(tok_ready), 0);
        chk("add N pop", int'(stk_pop), 1);
        chk("add N depth", int'(depth), 2);
        tick();
        chk("add N+1 pop", int'(stk_pop), 1);
        chk("add N+1 depth", int'(depth), 1);
        tick();
        chk("add N+2 pop", int'(stk_pop), 0);
        chk("add N+2 res_valid", int'(res_valid), 0);
        chk("add N+2 depth", int'(depth), 0);
        tick();
        chk("add N+3 res_valid", int'(res_valid), 1);
        chk("add N+3 res_data", int'(res_data), 7);
        chk("add N+3 push", int'(stk_push), 1);
        chk("add N+3 tok_ready", int'(tok_ready), 0);
        tick();
        chk("add N+4 res_valid", int'(res_valid), 0);
        chk("add N+4 res_data hold", int'(res_data), 7);
        chk("add N+4 depth", int'(depth), 1);
        chk("add N+4 tok_ready", int'(tok_ready), 1);
        chk("add N+4 err", int'(err_code), 0);

        for (int i = 0; i < 20; i++) begin
            p0 = push_cnt; q0 = pop_cnt; r0 = res_cnt;
            if (vecs[i].kind == 2) begin
                clr_err = 1'b1; tick(); clr_err = 1'b0;
            end else begin
                send(vecs[i].kind == 1, vecs[i].data, vecs[i].clr);
            end
            repeat (6) tick();
            chk($sformatf("vec%0d depth", i), int'(depth), int'(vecs[i].exp_depth));
            chk($sformatf("vec%0d err", i), int'(err_code), int'(vecs[i].exp_err));
            chk($sformatf("vec%0d pushes", i), push_cnt - p0, vecs[i].exp_push);
            chk($sformatf("vec%0d pops", i), pop_cnt - q0, vecs[i].exp_pop);
            chk($sformatf("vec%0d results", i), res_cnt - r0, vecs[i].exp_res);
            if (vecs[i].exp_res == 1)
                chk($sformatf("vec%0d res_data", i), int'(last_res), int'(vecs[i].exp_val));
        end

        // 9 operands back-to-back with tok_valid held high
        rstN = 1'b0; repeat (2) tick(); rstN = 1'b1; tick();
        p0 = push_cnt;
        tok_valid = 1'b1; tok_is_op = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tok_data = 4'(i + 1);
            wait_ready("ovf");
            tick();
        end
        tok_valid = 1'b0;
        repeat (3) tick();
        chk("ovf depth", int'(depth), 8);
        chk("ovf err", int'(err_code), 1);
        chk("ovf pushes", push_cnt - p0, 8);
        chk("ovf stk_full", int'(stk_full), 1);

        // reset in the POP_A cycle, then recover
        rstN = 1'b0; tick(); rstN = 1'b1; tick();
        chk("rst2 depth", int'(depth), 0);
        chk("rst2 err", int'(err_code), 0);
        send(0, 4'h5, 0); send(0, 4'h6, 0);
        send(1, 4'h0, 0);
        chk("mid POP_B pop", int'(stk_pop), 1);
        tick();
        chk("mid POP_A pop", int'(stk_pop), 1);
        rstN = 1'b0;
        tick();
        chk("mid rst depth", int'(depth), 0);
        chk("mid rst res_valid", int'(res_valid), 0);
        chk("mid rst push/pop", int'(stk_push) + int'(stk_pop), 0);
        chk("mid rst tok_ready", int'(tok_ready), 0);
        rstN = 1'b1;
        tick();
        r0 = res_cnt;
        send(0, 4'h2, 0); send(0, 4'h1, 0); send(1, 4'h2, 0);
        repeat (6) tick();
        chk("post-rst AND results", res_cnt - r0, 1);
        chk("post-rst AND res_data", int'(last_res), 0);
        chk("post-rst depth", int'(depth), 1);
        chk("push/pop overlap", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
